// File: rtl/top.sv
// Five-stage RV32I core (IF/ID/EX/MEM/WB); writeback lands 4 cycles after fetch, EX-resolved branches flush two slots.
// No external backpressure: a load-use pair holds pc and IF/ID for one cycle and forwards the load from MEM/WB.
module top_regfile (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      Registers[i_wa] <= i_wd;
    end
  end

  // A write retiring this cycle is visible to the ID read in the same cycle.
  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : Registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : Registers[i_ra2];
endmodule

module top #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] data,
  output logic [31:0] pc,
  output logic [31:0] rd_data,
  output logic [31:0] Read_data_2,
  output logic        MemREAD,
  output logic [1:0]  MemWrite
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_pc, r_ifid_pc, r_ifid_ins;
  logic [31:0] r_idex_pc, r_idex_ins, r_idex_a, r_idex_b;
  logic        r_exmem_wen, r_exmem_ld, r_exmem_st;
  logic [4:0]  r_exmem_rd;
  logic [2:0]  r_exmem_f3;
  logic [31:0] r_exmem_res, r_exmem_sd;
  logic        r_memwb_wen, r_memwb_ld;
  logic [4:0]  r_memwb_rd;
  logic [2:0]  r_memwb_f3;
  logic [1:0]  r_memwb_off;
  logic [31:0] r_memwb_res, r_memwb_dat;

  logic [31:0] w_rd1, w_rd2, w_fa, w_fb, w_opb, w_alu, w_ex_res, w_target, w_wb_val, w_ld;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [6:0]  w_ex_op;
  logic [4:0]  w_ex_rd, w_ex_rs1, w_ex_rs2, w_id_rs1, w_id_rs2;
  logic [2:0]  w_ex_f3;
  logic        w_ex_wen, w_cond, w_taken, w_ld_stall;
  logic [7:0]  w_lb;
  logic [15:0] w_lh;

  assign w_id_rs1 = r_ifid_ins[19:15];
  assign w_id_rs2 = r_ifid_ins[24:20];

  top_regfile regfile (
    .i_clk(clk), .i_rst(rst), .i_we(r_memwb_wen), .i_wa(r_memwb_rd), .i_wd(w_wb_val),
    .i_ra1(w_id_rs1), .i_ra2(w_id_rs2), .o_rd1(w_rd1), .o_rd2(w_rd2)
  );

  assign w_ex_op  = r_idex_ins[6:0];
  assign w_ex_rd  = r_idex_ins[11:7];
  assign w_ex_f3  = r_idex_ins[14:12];
  assign w_ex_rs1 = r_idex_ins[19:15];
  assign w_ex_rs2 = r_idex_ins[24:20];
  assign w_imm_i  = {{20{r_idex_ins[31]}}, r_idex_ins[31:20]};
  assign w_imm_s  = {{20{r_idex_ins[31]}}, r_idex_ins[31:25], r_idex_ins[11:7]};
  assign w_imm_b  = {{19{r_idex_ins[31]}}, r_idex_ins[31], r_idex_ins[7], r_idex_ins[30:25], r_idex_ins[11:8], 1'b0};
  assign w_imm_u  = {r_idex_ins[31:12], 12'b0};
  assign w_imm_j  = {{11{r_idex_ins[31]}}, r_idex_ins[31], r_idex_ins[19:12], r_idex_ins[20], r_idex_ins[30:21], 1'b0};

  assign w_ld_stall = (w_ex_op == OP_LD) && (w_ex_rd != 5'd0) && (w_ex_rd == w_id_rs1 || w_ex_rd == w_id_rs2);

  // Writer enables already exclude rd=x0, so a zero-rd producer never forwards.
  always_comb begin
    w_fa = r_idex_a;
    if (r_exmem_wen && r_exmem_rd == w_ex_rs1)      w_fa = r_exmem_res;
    else if (r_memwb_wen && r_memwb_rd == w_ex_rs1) w_fa = w_wb_val;
    w_fb = r_idex_b;
    if (r_exmem_wen && r_exmem_rd == w_ex_rs2)      w_fb = r_exmem_res;
    else if (r_memwb_wen && r_memwb_rd == w_ex_rs2) w_fb = w_wb_val;
  end

  always_comb begin
    w_opb = (w_ex_op == OP_REG) ? w_fb : w_imm_i;
    case (w_ex_f3)
      3'b000:  w_alu = (w_ex_op == OP_REG && r_idex_ins[30]) ? w_fa - w_opb : w_fa + w_opb;
      3'b001:  w_alu = w_fa << w_opb[4:0];
      3'b010:  w_alu = {31'b0, $signed(w_fa) < $signed(w_opb)};
      3'b011:  w_alu = {31'b0, w_fa < w_opb};
      3'b100:  w_alu = w_fa ^ w_opb;
      3'b101:  w_alu = r_idex_ins[30] ? 32'($signed(w_fa) >>> w_opb[4:0]) : w_fa >> w_opb[4:0];
      3'b110:  w_alu = w_fa | w_opb;
      default: w_alu = w_fa & w_opb;
    endcase
    case (w_ex_f3)
      3'b000:  w_cond = (w_fa == w_fb);
      3'b001:  w_cond = (w_fa != w_fb);
      3'b100:  w_cond = ($signed(w_fa) < $signed(w_fb));
      3'b101:  w_cond = ($signed(w_fa) >= $signed(w_fb));
      3'b110:  w_cond = (w_fa < w_fb);
      3'b111:  w_cond = (w_fa >= w_fb);
      default: w_cond = 1'b0;
    endcase
    w_taken  = (w_ex_op == OP_BR && w_cond) || w_ex_op == OP_JAL || w_ex_op == OP_JALR;
    w_target = (w_ex_op == OP_JALR) ? ((w_fa + w_imm_i) & ~32'd1)
             : r_idex_pc + ((w_ex_op == OP_JAL) ? w_imm_j : w_imm_b);
    case (w_ex_op)
      OP_LUI:          w_ex_res = w_imm_u;
      OP_AUIPC:        w_ex_res = r_idex_pc + w_imm_u;
      OP_JAL, OP_JALR: w_ex_res = r_idex_pc + 32'd4;
      OP_LD:           w_ex_res = w_fa + w_imm_i;
      OP_ST:           w_ex_res = w_fa + w_imm_s;
      default:         w_ex_res = w_alu;
    endcase
    w_ex_wen = (w_ex_rd != 5'd0) &&
               (w_ex_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG});
  end

  always_comb begin
    case (r_memwb_off)
      2'd0:    w_lb = r_memwb_dat[7:0];
      2'd1:    w_lb = r_memwb_dat[15:8];
      2'd2:    w_lb = r_memwb_dat[23:16];
      default: w_lb = r_memwb_dat[31:24];
    endcase
    w_lh = r_memwb_off[1] ? r_memwb_dat[31:16] : r_memwb_dat[15:0];
    case (r_memwb_f3)
      3'b000:  w_ld = {{24{w_lb[7]}}, w_lb};
      3'b001:  w_ld = {{16{w_lh[15]}}, w_lh};
      3'b100:  w_ld = {24'b0, w_lb};
      3'b101:  w_ld = {16'b0, w_lh};
      default: w_ld = r_memwb_dat;
    endcase
    w_wb_val = r_memwb_ld ? w_ld : r_memwb_res;
  end

  // Bubbles are canonical NOPs (addi x0,x0,0): no write, no memory access, no hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ifid_pc <= '0; r_ifid_ins <= NOP;
      r_idex_pc <= '0; r_idex_ins <= NOP; r_idex_a <= '0; r_idex_b <= '0;
      r_exmem_wen <= 1'b0; r_exmem_ld <= 1'b0; r_exmem_st <= 1'b0; r_exmem_rd <= '0;
      r_exmem_f3 <= '0; r_exmem_res <= '0; r_exmem_sd <= '0;
      r_memwb_wen <= 1'b0; r_memwb_ld <= 1'b0; r_memwb_rd <= '0; r_memwb_f3 <= '0;
      r_memwb_off <= '0; r_memwb_res <= '0; r_memwb_dat <= '0;
    end else begin
      if (w_taken) begin
        r_pc <= w_target;
        r_ifid_ins <= NOP;
        r_idex_ins <= NOP;
      end else if (w_ld_stall) begin
        r_idex_ins <= NOP;
      end else begin
        r_pc <= r_pc + 32'd4;
        r_ifid_pc <= r_pc;
        r_ifid_ins <= instruction;
        r_idex_pc <= r_ifid_pc;
        r_idex_ins <= r_ifid_ins;
        r_idex_a <= w_rd1;
        r_idex_b <= w_rd2;
      end
      r_exmem_wen <= w_ex_wen;
      r_exmem_ld  <= (w_ex_op == OP_LD);
      r_exmem_st  <= (w_ex_op == OP_ST);
      r_exmem_rd  <= w_ex_rd;
      r_exmem_f3  <= w_ex_f3;
      r_exmem_res <= w_ex_res;
      r_exmem_sd  <= w_fb;
      r_memwb_wen <= r_exmem_wen;
      r_memwb_ld  <= r_exmem_ld;
      r_memwb_rd  <= r_exmem_rd;
      r_memwb_f3  <= r_exmem_f3;
      r_memwb_off <= r_exmem_res[1:0];
      r_memwb_res <= r_exmem_res;
      r_memwb_dat <= data;
    end
  end

  assign pc          = r_pc;
  assign rd_data     = r_exmem_res;
  assign Read_data_2 = r_exmem_sd;
  assign MemREAD     = r_exmem_ld;
  assign MemWrite    = !r_exmem_st ? 2'b00 : r_exmem_f3[1] ? 2'b11 : {r_exmem_f3[0], ~r_exmem_f3[0]};
endmodule

// File: tb/tb_top.sv
// Directed bench for the RV32I core: behavioural instruction/data memories around the DUT.
module tb_top;
  logic        clk, rst;
  logic [31:0] instruction, data, pc, rd_data, Read_data_2;
  logic        MemREAD;
  logic [1:0]  MemWrite;
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:1023];
  logic        dmem_clr;
  int          errors = 0;
  int          checks = 0;

  top #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .data(data), .pc(pc),
    .rd_data(rd_data), .Read_data_2(Read_data_2), .MemREAD(MemREAD), .MemWrite(MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = imem[pc[9:2]];
  assign data        = dmem[rd_data[11:2]];

  always @(posedge clk) begin
    if (dmem_clr) begin
      for (int k = 0; k < 1024; k++) dmem[k] <= '0;
    end else if (!rst) begin
      if (MemWrite == 2'b01)      dmem[rd_data[11:2]][{rd_data[1:0], 3'b000} +: 8] <= Read_data_2[7:0];
      else if (MemWrite == 2'b10) dmem[rd_data[11:2]][{rd_data[1], 4'b0000} +: 16] <= Read_data_2[15:0];
      else if (MemWrite == 2'b11) dmem[rd_data[11:2]] <= Read_data_2;
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 256; k++) imem[k] = 32'h0000_0013;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    dmem_clr = 1'b1;
    tick();
    tick();
    dmem_clr = 1'b0;
  endtask

  function automatic logic [31:0] rf(input int idx);
    return dut.regfile.Registers[idx];
  endfunction

  logic found;

  initial begin
    rst = 1'b1;
    dmem_clr = 1'b1;
    clear_imem();

    // Reset with NOP memory
    hold_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd2", Read_data_2, 32'h0);
    check("rst_memread", {31'b0, MemREAD}, 32'h0);
    check("rst_memwrite", {30'b0, MemWrite}, 32'h0);
    for (int r = 0; r < 32; r++) check($sformatf("rst_x%0d", r), rf(r), 32'h0);
    rst = 1'b0;
    tick();
    check("nop_pc1", pc, 32'h4);
    tick();
    check("nop_pc2", pc, 32'h8);
    repeat (4) tick();
    check("nop_memwrite", {30'b0, MemWrite}, 32'h0);

    // ALU chain, store/load, load-use
    rst = 1'b1;
    clear_imem();
    imem[0]  = addi(5'd1, 5'd0, 32'd10);
    imem[1]  = addi(5'd2, 5'd0, 32'd5);
    imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    imem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    imem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd5);
    imem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd6);
    imem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd7);
    imem[7]  = enc_i(32'd5, 5'd1, 3'b001, 5'd8, 7'h13);
    imem[8]  = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd9);
    imem[9]  = addi(5'd10, 5'd0, 32'h100);
    imem[10] = enc_i(32'd2, 5'd10, 3'b001, 5'd10, 7'h13);
    imem[11] = enc_s(32'd0, 5'd3, 5'd10, 3'b010);
    imem[12] = enc_i(32'd0, 5'd10, 3'b010, 5'd23, 7'h03);
    imem[13] = enc_r(7'h00, 5'd1, 5'd23, 3'b000, 5'd24);
    hold_reset();
    rst = 1'b0;
    repeat (14) tick();
    check("sw_memwrite", {30'b0, MemWrite}, 32'h3);
    check("sw_addr", rd_data, 32'h400);
    check("sw_data", Read_data_2, 32'hF);
    check("pc_c14", pc, 32'h38);
    tick();
    check("lw_memread", {31'b0, MemREAD}, 32'h1);
    check("lw_addr", rd_data, 32'h400);
    check("stall_pc_hold", pc, 32'h38);
    tick();
    check("stall_pc_resume", pc, 32'h3c);
    repeat (12) tick();
    check("x1", rf(1), 32'd10);
    check("x2", rf(2), 32'd5);
    check("add_x3", rf(3), 32'hF);
    check("sub_x4", rf(4), 32'h5);
    check("and_x5", rf(5), 32'h0);
    check("or_x6", rf(6), 32'hF);
    check("xor_x7", rf(7), 32'hF);
    check("slli_x8", rf(8), 32'h140);
    check("srl_x9", rf(9), 32'h0);
    check("base_x10", rf(10), 32'h400);
    check("dmem_word", dmem[256], 32'hF);
    check("lw_x23", rf(23), 32'hF);
    check("loaduse_x24", rf(24), 32'h19);

    // Branches: each taken one skips two wrong-path writes to x30/x31
    rst = 1'b1;
    clear_imem();
    imem[0] = addi(5'd1, 5'd0, 32'hFFFF_FFFF);
    imem[1] = addi(5'd2, 5'd0, 32'd1);
    imem[2]  = enc_b(32'd12, 5'd2, 5'd2, 3'b000);
    imem[6]  = enc_b(32'd12, 5'd2, 5'd1, 3'b001);
    imem[10] = enc_b(32'd12, 5'd2, 5'd1, 3'b100);
    imem[14] = enc_b(32'd12, 5'd1, 5'd2, 3'b101);
    imem[18] = enc_b(32'd12, 5'd1, 5'd2, 3'b110);
    imem[22] = enc_b(32'd12, 5'd2, 5'd1, 3'b111);
    for (int b = 0; b < 6; b++) begin
      imem[3 + 4*b] = addi(5'd30, 5'd0, 32'd9);
      imem[4 + 4*b] = addi(5'd31, 5'd0, 32'd7);
      imem[5 + 4*b] = addi(5'(14 + b), 5'd0, 32'd1);
    end
    imem[26] = enc_b(32'd8, 5'd1, 5'd2, 3'b100);
    imem[27] = addi(5'd20, 5'd0, 32'd1);
    imem[28] = addi(5'd29, 5'd0, 32'd3);
    hold_reset();
    check("reset_clears_x24", rf(24), 32'h0);
    rst = 1'b0;
    repeat (60) tick();
    check("beq_x14", rf(14), 32'd1);
    check("bne_x15", rf(15), 32'd1);
    check("blt_x16", rf(16), 32'd1);
    check("bge_x17", rf(17), 32'd1);
    check("bltu_x18", rf(18), 32'd1);
    check("bgeu_x19", rf(19), 32'd1);
    check("notaken_x20", rf(20), 32'd1);
    check("after_x29", rf(29), 32'd3);
    check("wrongpath_x30", rf(30), 32'd0);
    check("wrongpath_x31", rf(31), 32'd0);

    // JAL/JALR then byte/half stores and loads
    rst = 1'b1;
    clear_imem();
    imem[0]  = enc_j(32'd16, 5'd21);
    imem[1]  = addi(5'd21, 5'd21, 32'd38);
    imem[2]  = enc_j(32'd16, 5'd0);
    imem[3]  = addi(5'd31, 5'd0, 32'd5);
    imem[4]  = enc_i(32'd1, 5'd21, 3'b000, 5'd22, 7'h67);
    imem[5]  = addi(5'd30, 5'd0, 32'd6);
    imem[6]  = addi(5'd22, 5'd22, 32'd22);
    imem[7]  = addi(5'd1, 5'd0, 32'h80);
    imem[8]  = addi(5'd2, 5'd0, 32'h400);
    imem[9]  = enc_s(32'd0, 5'd1, 5'd2, 3'b000);
    imem[10] = enc_i(32'd8, 5'd1, 3'b001, 5'd3, 7'h13);
    imem[11] = enc_s(32'd6, 5'd3, 5'd2, 3'b001);
    imem[12] = enc_i(32'd0, 5'd2, 3'b000, 5'd4, 7'h03);
    imem[13] = enc_i(32'd0, 5'd2, 3'b100, 5'd5, 7'h03);
    imem[14] = enc_i(32'd6, 5'd2, 3'b001, 5'd6, 7'h03);
    imem[15] = enc_i(32'd6, 5'd2, 3'b101, 5'd7, 7'h03);
    imem[16] = enc_i(32'd7, 5'd2, 3'b000, 5'd8, 7'h03);
    hold_reset();
    rst = 1'b0;
    repeat (2) tick();
    check("jal_pc_c2", pc, 32'h8);
    tick();
    check("jal_redirect_pc", pc, 32'h10);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (MemWrite != 2'b00) found = 1'b1;
    end
    check("sb_seen", {31'b0, found}, 32'h1);
    check("sb_memwrite", {30'b0, MemWrite}, 32'h1);
    check("sb_addr", rd_data, 32'h400);
    check("sb_data", Read_data_2 & 32'hFF, 32'h80);
    tick();
    tick();
    check("sh_memwrite", {30'b0, MemWrite}, 32'h2);
    check("sh_addr", rd_data, 32'h406);
    check("sh_data", Read_data_2 & 32'hFFFF, 32'h8000);
    repeat (20) tick();
    check("x0_zero", rf(0), 32'h0);
    check("jal_x21", rf(21), 32'h2a);
    check("jalr_x22", rf(22), 32'h2a);
    check("skip_x30", rf(30), 32'h0);
    check("skip_x31", rf(31), 32'h0);
    check("sb_mem", dmem[256], 32'h0000_0080);
    check("sh_mem", dmem[257], 32'h8000_0000);
    check("lb_x4", rf(4), 32'hFFFF_FF80);
    check("lbu_x5", rf(5), 32'h0000_0080);
    check("lh_x6", rf(6), 32'hFFFF_8000);
    check("lhu_x7", rf(7), 32'h0000_8000);
    check("lb_lane3_x8", rf(8), 32'hFFFF_FF80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
